// File: rtl/pwm_mon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_mon_pkg
//  Purpose  : Shared types and helpers for the DPWM gate-pair monitor.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_mon_pkg;

    localparam int c_cnt_w_default = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        DEAD1 = 3'd2,
        LO    = 3'd3,
        DEAD2 = 3'd4
    } state_t;

    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_edge_det
//  Purpose  : Two-stage sampler giving the registered level plus rise/fall.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_s_q;
    logic r_p_q;
    logic w_s_d;
    logic w_p_d;

    always_comb begin
        w_s_d = i_d;
        w_p_d = r_s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q <= 1'b0;
            r_p_q <= 1'b0;
        end else begin
            r_s_q <= w_s_d;
            r_p_q <= w_p_d;
        end
    end

    assign o_s    = r_s_q;
    assign o_rise = r_s_q & ~r_p_q;
    assign o_fall = ~r_s_q & r_p_q;

endmodule
`default_nettype wire

// File: rtl/pwm_gate_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_gate_monitor
//  Purpose  : Decodes the high/low gate pair into per-period widths and
//             deadtimes, and raises overlap / deadtime / timeout faults.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_gate_monitor
    import pwm_mon_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             gate_hi,
    input  logic             gate_lo,
    input  logic [CNT_W-1:0] cfg_min_dead,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] hi_width,
    output logic [CNT_W-1:0] dead_hl,
    output logic [CNT_W-1:0] lo_width,
    output logic [CNT_W-1:0] dead_lh,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             lo_missing,
    output logic             fault_overlap,
    output logic             fault_dead,
    output logic             fault_timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam int               c_meas_w  = 5 * CNT_W + 1;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), 32'(c_cnt_max)));
    endfunction

    logic w_s_hi, w_hi_rise, w_hi_fall;
    logic w_s_lo, w_lo_rise, w_lo_fall;

    pwm_edge_det u_hi_det (
        .clk    (clk),
        .rst    (rst),
        .i_d    (gate_hi),
        .o_s    (w_s_hi),
        .o_rise (w_hi_rise),
        .o_fall (w_hi_fall)
    );

    pwm_edge_det u_lo_det (
        .clk    (clk),
        .rst    (rst),
        .i_d    (gate_lo),
        .o_s    (w_s_lo),
        .o_rise (w_lo_rise),
        .o_fall (w_lo_fall)
    );

    state_t              r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_per_q, w_per_d;
    logic [CNT_W-1:0]    r_hi_q, w_hi_d;
    logic [CNT_W-1:0]    r_dhl_q, w_dhl_d;
    logic [CNT_W-1:0]    r_lo_q, w_lo_d;
    logic [CNT_W-1:0]    r_dlh_q, w_dlh_d;
    logic                r_first_q, w_first_d;
    logic                r_pend_q, w_pend_d;
    logic [c_meas_w-1:0] r_snap_q, w_snap_d;
    logic [c_meas_w-1:0] r_res_q, w_res_d;
    logic                r_mv_q, w_mv_d;
    logic                r_f_ov_q, w_f_ov_d;
    logic                r_f_dead_q, w_f_dead_d;
    logic                r_f_to_q, w_f_to_d;

    logic w_overlap, w_close, w_miss;
    logic w_set_ov, w_set_dead, w_set_to;
    logic w_dhl_short, w_dlh_short;

    assign w_overlap   = w_s_hi & w_s_lo;
    assign w_dhl_short = (cfg_min_dead != '0) && (r_dhl_q < cfg_min_dead);
    assign w_dlh_short = (cfg_min_dead != '0) && (r_dlh_q < cfg_min_dead);

    always_comb begin
        w_state_d  = r_state_q;
        w_per_d    = r_per_q;
        w_hi_d     = r_hi_q;
        w_dhl_d    = r_dhl_q;
        w_lo_d     = r_lo_q;
        w_dlh_d    = r_dlh_q;
        w_first_d  = r_first_q;
        w_pend_d   = 1'b0;
        w_snap_d   = r_snap_q;
        w_close    = 1'b0;
        w_miss     = 1'b0;
        w_set_ov   = 1'b0;
        w_set_dead = 1'b0;
        w_set_to   = 1'b0;

        if (!en) begin
            w_state_d = IDLE;
            w_per_d   = '0;
        end else if (w_overlap) begin
            w_set_ov  = 1'b1;
            w_state_d = IDLE;
            w_per_d   = '0;
        end else begin
            if (r_state_q != IDLE) begin
                w_per_d = inc(r_per_q);
            end
            case (r_state_q)
                IDLE: begin
                    if (w_hi_rise) begin
                        w_state_d = HI;
                        w_hi_d    = c_cnt_one;
                        w_per_d   = c_cnt_one;
                        w_dhl_d   = '0;
                        w_lo_d    = '0;
                        w_dlh_d   = '0;
                        w_first_d = 1'b1;
                    end
                end
                HI: begin
                    if (w_hi_fall) begin
                        w_state_d = DEAD1;
                        w_dhl_d   = c_cnt_one;
                    end else begin
                        w_hi_d = inc(r_hi_q);
                    end
                end
                DEAD1: begin
                    if (w_lo_rise) begin
                        w_state_d  = LO;
                        w_lo_d     = c_cnt_one;
                        w_set_dead = w_dhl_short;
                    end else if (w_hi_rise) begin
                        w_close = 1'b1;
                        w_miss  = 1'b1;
                    end else begin
                        w_dhl_d = inc(r_dhl_q);
                    end
                end
                LO: begin
                    if (w_lo_fall) begin
                        w_state_d = DEAD2;
                        w_dlh_d   = c_cnt_one;
                    end else begin
                        w_lo_d = inc(r_lo_q);
                    end
                end
                DEAD2: begin
                    if (w_hi_rise) begin
                        w_close    = 1'b1;
                        w_set_dead = w_dlh_short;
                    end else begin
                        w_dlh_d = inc(r_dlh_q);
                    end
                end
                default: w_state_d = IDLE;
            endcase

            if (w_close) begin
                // The period opened from IDLE may have started mid-stream, so it is never reported.
                w_snap_d  = {r_hi_q, r_dhl_q,
                             (w_miss ? {CNT_W{1'b0}} : r_lo_q),
                             (w_miss ? {CNT_W{1'b0}} : r_dlh_q),
                             r_per_q, w_miss};
                w_pend_d  = ~r_first_q;
                w_first_d = 1'b0;
                w_state_d = HI;
                w_hi_d    = c_cnt_one;
                w_per_d   = c_cnt_one;
                w_dhl_d   = '0;
                w_lo_d    = '0;
                w_dlh_d   = '0;
            end else if ((r_state_q != IDLE) && (r_per_q == c_cnt_max)) begin
                w_set_to  = 1'b1;
                w_state_d = IDLE;
                w_per_d   = '0;
            end
        end
    end

    always_comb begin
        w_mv_d     = r_pend_q & ~(en & w_overlap);
        w_res_d    = w_mv_d ? r_snap_q : r_res_q;
        w_f_ov_d   = (r_f_ov_q & ~fault_clr) | w_set_ov;
        w_f_dead_d = (r_f_dead_q & ~fault_clr) | w_set_dead;
        w_f_to_d   = (r_f_to_q & ~fault_clr) | w_set_to;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_per_q    <= '0;
            r_hi_q     <= '0;
            r_dhl_q    <= '0;
            r_lo_q     <= '0;
            r_dlh_q    <= '0;
            r_first_q  <= 1'b0;
            r_pend_q   <= 1'b0;
            r_snap_q   <= '0;
            r_res_q    <= '0;
            r_mv_q     <= 1'b0;
            r_f_ov_q   <= 1'b0;
            r_f_dead_q <= 1'b0;
            r_f_to_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_per_q    <= w_per_d;
            r_hi_q     <= w_hi_d;
            r_dhl_q    <= w_dhl_d;
            r_lo_q     <= w_lo_d;
            r_dlh_q    <= w_dlh_d;
            r_first_q  <= w_first_d;
            r_pend_q   <= w_pend_d;
            r_snap_q   <= w_snap_d;
            r_res_q    <= w_res_d;
            r_mv_q     <= w_mv_d;
            r_f_ov_q   <= w_f_ov_d;
            r_f_dead_q <= w_f_dead_d;
            r_f_to_q   <= w_f_to_d;
        end
    end

    assign hi_width      = r_res_q[5*CNT_W -: CNT_W];
    assign dead_hl       = r_res_q[4*CNT_W -: CNT_W];
    assign lo_width      = r_res_q[3*CNT_W -: CNT_W];
    assign dead_lh       = r_res_q[2*CNT_W -: CNT_W];
    assign period        = r_res_q[CNT_W -: CNT_W];
    assign lo_missing    = r_res_q[0];
    assign meas_valid    = r_mv_q;
    assign fault_overlap = r_f_ov_q;
    assign fault_dead    = r_f_dead_q;
    assign fault_timeout = r_f_to_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gate_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_gate_monitor
//  Purpose  : Self-checking bench for pwm_gate_monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_gate_monitor;

    localparam int CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             en;
    logic             gate_hi;
    logic             gate_lo;
    logic [CNT_W-1:0] cfg_min_dead;
    logic             fault_clr;
    logic [CNT_W-1:0] hi_width, dead_hl, lo_width, dead_lh, period;
    logic             meas_valid, lo_missing, fault_overlap, fault_dead, fault_timeout;

    pwm_gate_monitor #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .cfg_min_dead  (cfg_min_dead),
        .fault_clr     (fault_clr),
        .hi_width      (hi_width),
        .dead_hl       (dead_hl),
        .lo_width      (lo_width),
        .dead_lh       (dead_lh),
        .period        (period),
        .meas_valid    (meas_valid),
        .lo_missing    (lo_missing),
        .fault_overlap (fault_overlap),
        .fault_dead    (fault_dead),
        .fault_timeout (fault_timeout)
    );

    typedef struct packed {
        logic [6:0] hi;
        logic [6:0] dhl;
        logic [6:0] lo;
        logic [6:0] dlh;
        logic [6:0] per;
        logic       miss;
    } meas_t;

    typedef struct {
        int    h;
        int    d1;
        int    l;
        int    d2;
        meas_t exp;
        bit    push;
    } vec_t;

    meas_t sb_q[$];
    vec_t  tbl[9];
    int    checks = 0;
    int    errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every result pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (meas_valid) begin
            meas_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL meas_unexpected: got meas_valid=1 per=%0d, expected no pulse", period);
            end else begin
                e = sb_q.pop_front();
                if ({hi_width, dead_hl, lo_width, dead_lh, period, lo_missing} !== e) begin
                    errors++;
                    $display("FAIL meas_record: got hi=%0d dhl=%0d lo=%0d dlh=%0d per=%0d miss=%0d, expected hi=%0d dhl=%0d lo=%0d dlh=%0d per=%0d miss=%0d",
                             hi_width, dead_hl, lo_width, dead_lh, period, lo_missing,
                             e.hi, e.dhl, e.lo, e.dlh, e.per, e.miss);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic vec_t mkv(int h, int d1, int l, int d2, int eh, int edhl, int el,
                                 int edlh, int eper, bit emiss, bit push);
        vec_t v;
        v.h = h; v.d1 = d1; v.l = l; v.d2 = d2;
        v.exp.hi = 7'(eh); v.exp.dhl = 7'(edhl); v.exp.lo = 7'(el);
        v.exp.dlh = 7'(edlh); v.exp.per = 7'(eper); v.exp.miss = emiss;
        v.push = push;
        return v;
    endfunction

    function automatic meas_t mk(int h, int d1, int l, int d2, int p, bit miss);
        meas_t m;
        m.hi = 7'(h); m.dhl = 7'(d1); m.lo = 7'(l); m.dlh = 7'(d2); m.per = 7'(p); m.miss = miss;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cycle(input logic h, input logic l);
        gate_hi = h;
        gate_lo = l;
        @(posedge clk);
        #1;
    endtask

    task automatic run_period(input int h, input int d1, input int l, input int d2, input int ov_at);
        for (int i = 0; i < h; i++)  set_cycle(1'b1, i == ov_at);
        for (int i = 0; i < d1; i++) set_cycle(1'b0, 1'b0);
        for (int i = 0; i < l; i++)  set_cycle(1'b0, 1'b1);
        for (int i = 0; i < d2; i++) set_cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1; en = 1'b1; gate_hi = 1'b0; gate_lo = 1'b0; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(name, {hi_width, dead_hl, lo_width, dead_lh, period, meas_valid, lo_missing,
                   fault_overlap, fault_dead, fault_timeout}, 64'd0);
        sb_q.delete();
        rst = 1'b0;
        set_cycle(1'b0, 1'b0);
    endtask

    // Closing rise: result pulse lands on the third edge after gate_hi is first sampled high.
    task automatic finish_stream();
        gate_hi = 1'b1;
        gate_lo = 1'b0;
        @(posedge clk); #1; chk("latency_edge1", meas_valid, 0);
        @(posedge clk); #1; chk("latency_edge2", meas_valid, 0);
        @(posedge clk); #1; chk("latency_edge3", meas_valid, 1);
        gate_hi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; gate_hi = 1'b0; gate_lo = 1'b0;
        fault_clr = 1'b0; cfg_min_dead = 7'd2;

        tbl[0] = mkv( 20, 10, 30, 4,   20, 10, 30, 4,  64, 1'b0, 1'b0);
        tbl[1] = mkv( 20, 10, 30, 4,   20, 10, 30, 4,  64, 1'b0, 1'b1);
        tbl[2] = mkv( 20, 10, 30, 4,   20, 10, 30, 4,  64, 1'b0, 1'b1);
        tbl[3] = mkv(  5,  3,  7, 2,    5,  3,  7, 2,  17, 1'b0, 1'b1);
        tbl[4] = mkv( 60,  4,  0, 0,   60,  4,  0, 0,  64, 1'b1, 1'b1);
        tbl[5] = mkv(  1,  2,  1, 2,    1,  2,  1, 2,   6, 1'b0, 1'b1);
        tbl[6] = mkv( 30,  2, 40, 3,   30,  2, 40, 3,  75, 1'b0, 1'b1);
        tbl[7] = mkv( 10,  5, 10, 5,   10,  5, 10, 5,  30, 1'b0, 1'b1);
        tbl[8] = mkv(100, 10, 10, 6,  100, 10, 10, 6, 126, 1'b0, 1'b1);

        // Nominal stream and assorted shapes
        do_reset("reset_state");
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].push) sb_q.push_back(tbl[i].exp);
            run_period(tbl[i].h, tbl[i].d1, tbl[i].l, tbl[i].d2, -1);
        end
        finish_stream();
        chk("nominal_no_faults", {fault_overlap, fault_dead, fault_timeout}, 0);

        // Short deadtime with sticky clear
        do_reset("reset_short_dead");
        run_period(20, 10, 30, 1, -1);
        sb_q.push_back(mk(20, 10, 30, 1, 61, 1'b0));
        run_period(20, 10, 30, 1, -1);
        chk("dead_first_period", fault_dead, 1);
        sb_q.push_back(mk(20, 10, 30, 1, 61, 1'b0));
        for (int i = 0; i < 20; i++) begin
            fault_clr = (i == 1) || (i == 5);
            set_cycle(1'b1, 1'b0);
            if (i == 1) chk("dead_clr_same_cycle", fault_dead, 1);
            if (i == 5) chk("dead_cleared", fault_dead, 0);
        end
        fault_clr = 1'b0;
        run_period(0, 10, 30, 1, -1);
        chk("dead_stays_clear", fault_dead, 0);
        finish_stream();
        chk("dead_set_again", fault_dead, 1);

        // Overlap during HI
        do_reset("reset_overlap");
        run_period(20, 10, 30, 4, -1);
        sb_q.push_back(mk(20, 10, 30, 4, 64, 1'b0));
        run_period(20, 10, 30, 4, -1);
        run_period(20, 10, 30, 4, 4);
        chk("overlap_set", fault_overlap, 1);
        run_period(20, 10, 30, 4, -1);
        sb_q.push_back(mk(20, 10, 30, 4, 64, 1'b0));
        run_period(20, 10, 30, 4, -1);
        finish_stream();
        fault_clr = 1'b1;
        set_cycle(1'b0, 1'b0);
        fault_clr = 1'b0;
        chk("overlap_cleared", fault_overlap, 0);

        // Timeout: one hi pulse then silence
        do_reset("reset_timeout");
        for (int i = 0; i < 5; i++) set_cycle(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            set_cycle(1'b0, 1'b0);
            if (i == 100) chk("timeout_not_yet", fault_timeout, 0);
        end
        chk("timeout_set", fault_timeout, 1);
        chk("timeout_no_result", period, 0);
        run_period(20, 10, 30, 4, -1);
        sb_q.push_back(mk(20, 10, 30, 4, 64, 1'b0));
        run_period(20, 10, 30, 4, -1);
        finish_stream();
        chk("timeout_sticky", fault_timeout, 1);

        // Reset in the middle of LO
        do_reset("reset_mid_pre");
        run_period(20, 10, 30, 4, -1);
        sb_q.push_back(mk(20, 10, 30, 4, 64, 1'b0));
        run_period(20, 10, 30, 4, -1);
        run_period(20, 10, 10, 0, -1);
        chk("pre_reset_hi_width", hi_width, 20);
        rst = 1'b1;
        set_cycle(1'b0, 1'b1);
        chk("reset_mid_lo", {hi_width, dead_hl, lo_width, dead_lh, period, meas_valid,
                             lo_missing, fault_overlap, fault_dead, fault_timeout}, 64'd0);
        rst = 1'b0;
        run_period(0, 0, 19, 4, -1);
        run_period(20, 10, 30, 4, -1);
        sb_q.push_back(mk(20, 10, 30, 4, 64, 1'b0));
        run_period(20, 10, 30, 4, -1);
        finish_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
